// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter: FSM states,
// requester index type and the default debug counter width.
package fifo_arb_pkg;

  localparam int FIFO_ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/fifo_arb_pick.sv
// Combinational winner selection between the two push requesters.
// FIFO_ARB_FIXED_PRIO_EN selects fixed priority (req0 first); default is round-robin.
module fifo_arb_pick
  import fifo_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last_grant,
  input  logic     full,
  output logic     grant_valid,
  output req_idx_t grant_idx
);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_valid = !full && (req0 || req1);
    grant_idx   = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    grant_idx = req0 ? 1'b0 : 1'b1;
`else
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req0 ? 1'b0 : 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Two-producer arbiter driving the push side of the I/O FIFO (PUSH/HOLD pacing).
// Build option: define FIFO_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = FIFO_ARB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             fifo_push_back,
  output logic [WIDTH-1:0] fifo_data_in,
  input  logic             fifo_full,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [WIDTH-1:0] data_reg;
  req_idx_t         last_grant;
  logic             grant_valid;
  req_idx_t         grant_idx;
  logic             take;

  fifo_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .full        (fifo_full),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A grant is only taken outside PUSH, which spaces pushes two cycles apart.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE, HOLD: begin
        take       = grant_valid;
        state_next = grant_valid ? PUSH : IDLE;
      end
      PUSH:    state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      data_reg       <= '0;
      fifo_push_back <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
      cnt0           <= '0;
      cnt1           <= '0;
    end else begin
      state          <= state_next;
      fifo_push_back <= take;
      ack0           <= take && (grant_idx == 1'b0);
      ack1           <= take && (grant_idx == 1'b1);
      busy           <= (state_next != IDLE);
      if (take) begin
        data_reg <= grant_idx ? data1 : data0;
        if (grant_idx) cnt1 <= cnt1 + CNT_W'(1);
        else           cnt0 <= cnt0 + CNT_W'(1);
      end
    end
  end

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign last_grant = 1'b1;
`else
  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= grant_idx;
    end
  end
`endif

  assign fifo_data_in = data_reg;

  a_no_back_to_back: assert property (
    @(posedge clk) disable iff (!rst) fifo_push_back |=> !fifo_push_back);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) fifo_push_back |-> !$past(fifo_full));

endmodule
